// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: predictor modes,
// 2-bit counter encodings and the saturating counter update rule.
package bpu_pkg;

    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;
    localparam int MODE_GSHARE  = 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt2_e;

    function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (cur == ST) ? cur : cur + 2'd1;
        end else begin
            nxt = (cur == SNT) ? cur : cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bpu_pht.sv
// Pattern history table: 2-bit saturating counters, one combinational read
// port and one read-modify-write update port applied at the clock edge.
module bpu_pht
    import bpu_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             in_Clk,
    input  logic             Rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    localparam int N = 1 << IDX_W;

    logic [1:0] cnt_q [N];
    logic [1:0] cnt_d [N];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = sat_next(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge in_Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= WNT;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reads the registered value, so a same-cycle update is not visible yet.
    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/bpu_gshare_param.sv
// Branch prediction unit: selectable static/bimodal/gshare direction predictor,
// tagged direct-mapped BTB, speculative GHR with repair, mispredict counter.
module bpu_gshare_param
    import bpu_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MODE      = 2,
    parameter int PHT_IDX_W = 8,
    parameter int GHR_W     = 8,
    parameter int BTB_IDX_W = 6,
    parameter int TAG_W     = 16,
    parameter int CNT_W     = 32
) (
    input  logic                 in_Clk,
    input  logic                 Rst,
    input  logic                 in_fetch_valid,
    input  logic [XLEN-1:0]      in_fetch_pc,
    output logic                 out_prediction,
    output logic [XLEN-1:0]      out_pred_target,
    output logic [PHT_IDX_W-1:0] out_pred_idx,
    output logic [GHR_W-1:0]     out_ghr_snap,
    input  logic                 in_upd_valid,
    input  logic [XLEN-1:0]      in_upd_pc,
    input  logic [PHT_IDX_W-1:0] in_upd_idx,
    input  logic [GHR_W-1:0]     in_upd_ghr,
    input  logic                 in_upd_taken,
    input  logic [XLEN-1:0]      in_upd_target,
    input  logic                 in_upd_mispredict,
    output logic [CNT_W-1:0]     out_mispredict_cnt
);

    localparam int BTB_N = 1 << BTB_IDX_W;

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             btb_valid_q [BTB_N];
    logic             btb_valid_d [BTB_N];
    logic [TAG_W-1:0] btb_tag_q   [BTB_N];
    logic [TAG_W-1:0] btb_tag_d   [BTB_N];
    logic [XLEN-1:0]  btb_tgt_q   [BTB_N];
    logic [XLEN-1:0]  btb_tgt_d   [BTB_N];

    logic [PHT_IDX_W-1:0] pc_idx;
    logic [PHT_IDX_W-1:0] rd_idx;
    logic [1:0]           rd_cnt;
    logic [BTB_IDX_W-1:0] f_bidx;
    logic [BTB_IDX_W-1:0] u_bidx;
    logic [TAG_W-1:0]     f_tag;
    logic [TAG_W-1:0]     u_tag;
    logic                 btb_hit;
    logic                 pred;
    logic                 unused_bits;

    assign pc_idx = in_fetch_pc[PHT_IDX_W+1:2];
    assign rd_idx = (MODE == MODE_GSHARE) ? (pc_idx ^ PHT_IDX_W'(ghr_q)) : pc_idx;

    assign f_bidx = in_fetch_pc[BTB_IDX_W+1:2];
    assign f_tag  = in_fetch_pc[BTB_IDX_W+2 +: TAG_W];
    assign u_bidx = in_upd_pc[BTB_IDX_W+1:2];
    assign u_tag  = in_upd_pc[BTB_IDX_W+2 +: TAG_W];

    assign unused_bits = ^{in_fetch_pc, in_upd_pc, rd_cnt[0]};

    bpu_pht #(
        .IDX_W(PHT_IDX_W)
    ) u_pht (
        .in_Clk  (in_Clk),
        .Rst     (Rst),
        .rd_idx  (rd_idx),
        .rd_cnt  (rd_cnt),
        .wr_en   (in_upd_valid && (MODE != MODE_STATIC)),
        .wr_idx  (in_upd_idx),
        .wr_taken(in_upd_taken)
    );

    assign btb_hit = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
    assign pred    = (MODE != MODE_STATIC) && in_fetch_valid && rd_cnt[1] && btb_hit;

    assign out_prediction     = pred;
    assign out_pred_target    = pred ? btb_tgt_q[f_bidx] : '0;
    assign out_pred_idx       = rd_idx;
    assign out_ghr_snap       = ghr_q;
    assign out_mispredict_cnt = cnt_q;

    // The cast drops the oldest bit, which also covers the one-bit history case.
    always_comb begin
        ghr_d = ghr_q;
        if (in_upd_valid && in_upd_mispredict) begin
            ghr_d = GHR_W'({in_upd_ghr, in_upd_taken});
        end else if (in_fetch_valid && (MODE == MODE_GSHARE)) begin
            ghr_d = GHR_W'({ghr_q, pred});
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_upd_valid && in_upd_mispredict && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        btb_valid_d = btb_valid_q;
        btb_tag_d   = btb_tag_q;
        btb_tgt_d   = btb_tgt_q;
        if (in_upd_valid && in_upd_taken) begin
            btb_valid_d[u_bidx] = 1'b1;
            btb_tag_d[u_bidx]   = u_tag;
            btb_tgt_d[u_bidx]   = in_upd_target;
        end
    end

    always_ff @(posedge in_Clk or posedge Rst) begin
        if (Rst) begin
            ghr_q <= '0;
            cnt_q <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
            end
        end else begin
            ghr_q       <= ghr_d;
            cnt_q       <= cnt_d;
            btb_valid_q <= btb_valid_d;
            btb_tag_q   <= btb_tag_d;
            btb_tgt_q   <= btb_tgt_d;
        end
    end

endmodule

// File: tb/tb_bpu_gshare_param.sv
// Self-checking bench: gshare build and a static build with a 4-bit counter,
// compared every cycle against a table-level behavioural model.
module tb_bpu_gshare_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fv = 1'b0;
    logic [63:0] fpc = '0;
    logic        uv = 1'b0;
    logic [63:0] upc = '0;
    logic [7:0]  uidx = '0;
    logic [7:0]  ughr = '0;
    logic        utk = 1'b0;
    logic [63:0] utgt = '0;
    logic        umis = 1'b0;

    logic        pred, pred0;
    logic [63:0] tgt, tgt0;
    logic [7:0]  pidx, pidx0;
    logic [7:0]  snap, snap0;
    logic [31:0] cnt;
    logic [3:0]  cnt0;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state
    int          m_pht [256];
    bit          m_bv  [64];
    logic [15:0] m_btag[64];
    logic [63:0] m_btgt[64];
    int          m_ghr, m_ghr0;
    longint      m_cnt;
    int          m_cnt0;

    always #5 clk = ~clk;

    bpu_gshare_param u_dut (
        .in_Clk(clk), .Rst(rst),
        .in_fetch_valid(fv), .in_fetch_pc(fpc),
        .out_prediction(pred), .out_pred_target(tgt),
        .out_pred_idx(pidx), .out_ghr_snap(snap),
        .in_upd_valid(uv), .in_upd_pc(upc), .in_upd_idx(uidx), .in_upd_ghr(ughr),
        .in_upd_taken(utk), .in_upd_target(utgt), .in_upd_mispredict(umis),
        .out_mispredict_cnt(cnt)
    );

    bpu_gshare_param #(.MODE(0), .CNT_W(4)) u_dut0 (
        .in_Clk(clk), .Rst(rst),
        .in_fetch_valid(fv), .in_fetch_pc(fpc),
        .out_prediction(pred0), .out_pred_target(tgt0),
        .out_pred_idx(pidx0), .out_ghr_snap(snap0),
        .in_upd_valid(uv), .in_upd_pc(upc), .in_upd_idx(uidx), .in_upd_ghr(ughr),
        .in_upd_taken(utk), .in_upd_target(utgt), .in_upd_mispredict(umis),
        .out_mispredict_cnt(cnt0)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_pcidx(input logic [63:0] pc);
        return int'((pc >> 2) & 64'hFF);
    endfunction

    function automatic int m_bidx(input logic [63:0] pc);
        return int'((pc >> 2) & 64'h3F);
    endfunction

    function automatic bit m_hit(input logic [63:0] pc);
        int b = m_bidx(pc);
        return m_bv[b] && (m_btag[b] == 16'((pc >> 8) & 64'hFFFF));
    endfunction

    function automatic bit m_pred(input logic [63:0] pc);
        return fv && (m_pht[m_pcidx(pc) ^ m_ghr] >= 2) && m_hit(pc);
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 256; i++) m_pht[i] = 1;
        for (int i = 0; i < 64; i++) begin
            m_bv[i]   = 1'b0;
            m_btag[i] = '0;
            m_btgt[i] = '0;
        end
        m_ghr  = 0;
        m_ghr0 = 0;
        m_cnt  = 0;
        m_cnt0 = 0;
    endtask

    task automatic model_step();
        bit p = m_pred(fpc);
        if (uv && umis) begin
            m_ghr  = ((int'(ughr) << 1) | int'(utk)) & 255;
            m_ghr0 = m_ghr;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (m_cnt0 < 15) m_cnt0++;
        end else if (fv) begin
            m_ghr = ((m_ghr << 1) | int'(p)) & 255;
        end
        if (uv) begin
            if (utk) m_pht[uidx] = (m_pht[uidx] == 3) ? 3 : m_pht[uidx] + 1;
            else     m_pht[uidx] = (m_pht[uidx] == 0) ? 0 : m_pht[uidx] - 1;
        end
        if (uv && utk) begin
            m_bv[m_bidx(upc)]   = 1'b1;
            m_btag[m_bidx(upc)] = 16'((upc >> 8) & 64'hFFFF);
            m_btgt[m_bidx(upc)] = utgt;
        end
    endtask

    task automatic compare_all();
        bit p = m_pred(fpc);
        chk("pred", pred, p);
        chk("target", tgt, p ? m_btgt[m_bidx(fpc)] : 64'h0);
        chk("idx", pidx, m_pcidx(fpc) ^ m_ghr);
        chk("ghr_snap", snap, m_ghr);
        chk("mis_cnt", cnt, m_cnt);
        chk("m0_pred", pred0, 0);
        chk("m0_target", tgt0, 0);
        chk("m0_idx", pidx0, m_pcidx(fpc));
        chk("m0_ghr_snap", snap0, m_ghr0);
        chk("m0_cnt", cnt0, m_cnt0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_all();
            @(posedge clk);
            if (!rst) model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic [7:0] idx, input logic [7:0] g,
                       input logic tk, input logic [63:0] tg, input logic mis);
        fv = 1'b0; uv = 1'b1; upc = pc; uidx = idx; ughr = g; utk = tk; utgt = tg; umis = mis;
        tick();
        uv = 1'b0;
    endtask

    task automatic peek(input string nm, input logic [63:0] pc, input logic ep,
                        input logic [63:0] et, input logic [7:0] ei);
        fv = 1'b1; fpc = pc;
        @(negedge clk);
        #1;
        chk({nm, "_pred"}, pred, ep);
        chk({nm, "_target"}, tgt, et);
        chk({nm, "_idx"}, pidx, ei);
        fv = 1'b0;
        tick();
    endtask

    initial begin
        #1 rst = 1'b1;
        reset_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        chk("rst_cnt", cnt, 0);
        chk("rst_snap", snap, 0);
        peek("rst", 64'h1000, 1'b0, 64'h0, 8'h00);

        // Two taken mispredicts: counter 01->10->11, repair leaves GHR=1
        upd(64'h1000, 8'h01, 8'h00, 1'b1, 64'h0F00, 1'b1);
        upd(64'h1000, 8'h01, 8'h00, 1'b1, 64'h0F00, 1'b1);
        chk("train_cnt", cnt, 2);
        chk("train_snap", snap, 1);
        peek("train", 64'h1000, 1'b1, 64'h0F00, 8'h01);

        // Prime entry 0, then repair GHR to 0 with a not-taken mispredict
        upd(64'h1000, 8'h00, 8'h00, 1'b1, 64'h0F00, 1'b0);
        upd(64'h3000, 8'h80, 8'h00, 1'b0, 64'h0, 1'b1);
        chk("repair0_snap", snap, 0);

        // Two predicted-taken fetches shift GHR 0 -> 1 -> 3
        fv = 1'b1; fpc = 64'h1000;
        @(negedge clk); #1;
        chk("ghr_f1_pred", pred, 1);
        tick();
        @(negedge clk); #1;
        chk("ghr_f2_snap", snap, 1);
        chk("ghr_f2_pred", pred, 1);
        tick();
        chk("ghr_f3_snap", snap, 3);
        // Repair and fetch in the same cycle: repair wins
        uv = 1'b1; upc = 64'h3000; uidx = 8'h80; ughr = 8'h00; utk = 1'b0; umis = 1'b1;
        tick();
        uv = 1'b0; fv = 1'b0;
        chk("ghr_repair_snap", snap, 0);
        chk("ghr_repair_cnt", cnt, 4);

        // Alias: same BTB index, different tag
        upd(64'h1004, 8'h40, 8'h00, 1'b1, 64'h2222_0000, 1'b0);
        upd(64'h1004, 8'h40, 8'h00, 1'b1, 64'h2222_0000, 1'b0);
        peek("alias", 64'h1100, 1'b0, 64'h0, 8'h40);
        peek("alias_ref", 64'h1000, 1'b1, 64'h0F00, 8'h00);

        // Saturation at entry 0
        repeat (10) upd(64'h1000, 8'h00, 8'h00, 1'b1, 64'h0F00, 1'b0);
        peek("sat_hi", 64'h1000, 1'b1, 64'h0F00, 8'h00);
        upd(64'h1000, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);
        peek("dec1", 64'h1000, 1'b1, 64'h0F00, 8'h00);
        upd(64'h1000, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);
        peek("dec2", 64'h1000, 1'b0, 64'h0, 8'h00);
        upd(64'h1000, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);
        peek("dec3", 64'h1000, 1'b0, 64'h0, 8'h00);
        upd(64'h1000, 8'h00, 8'h00, 1'b0, 64'h0, 1'b0);
        peek("dec4", 64'h1000, 1'b0, 64'h0, 8'h00);

        // Mispredict counter saturation on the 4-bit static build
        repeat (20) upd(64'h3000, 8'h80, 8'h00, 1'b0, 64'h0, 1'b1);
        chk("cnt32_after20", cnt, 24);
        chk("cnt4_sat", cnt0, 15);

        // Randomized traffic over a small PC set with tag aliases
        for (int i = 0; i < 1500; i++) begin
            fv   = ($urandom_range(3) != 0);
            fpc  = 64'h1000 + 64'(4 * $urandom_range(15)) + 64'(($urandom_range(3) == 0) ? 256 : 0);
            uv   = $urandom_range(1);
            upc  = 64'h1000 + 64'(4 * $urandom_range(15)) + 64'(($urandom_range(3) == 0) ? 256 : 0);
            uidx = 8'($urandom_range(255));
            ughr = 8'($urandom_range(255));
            utk  = $urandom_range(1);
            utgt = {$urandom, $urandom} & ~64'h3;
            umis = ($urandom_range(9) < 3);
            tick();
        end

        // Reset asserted mid-cycle while an update and a fetch are in flight
        fv = 1'b1; fpc = 64'h1000;
        uv = 1'b1; upc = 64'h1000; uidx = 8'h00; ughr = 8'h00; utk = 1'b1; utgt = 64'h0F00; umis = 1'b1;
        #1 rst = 1'b1;
        reset_model();
        #1;
        chk("midrst_pred", pred, 0);
        chk("midrst_target", tgt, 0);
        chk("midrst_idx", pidx, 0);
        chk("midrst_snap", snap, 0);
        chk("midrst_cnt", cnt, 0);
        chk("midrst_cnt4", cnt0, 0);
        tick();
        tick();
        rst = 1'b0; uv = 1'b0; fv = 1'b0;
        peek("post_rst", 64'h1000, 1'b0, 64'h0, 8'h00);
        chk("post_rst_cnt", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bpu_gshare_param.md
Name: bpu_gshare_param

Overview:
- Parametrised branch prediction unit for the RV64IF fetch stage. Supplies the taken/not-taken prediction to the control unit and a predicted target to the PC mux.
- Generalises the single fixed predictor bit into a selectable predictor:
  - static not-taken,
  - bimodal,
  - gshare, with configurable table depth and history length.
- Adds a tagged BTB, speculative global history with mispredict repair, and a mispredict counter.

Parameters:
- XLEN, 64, address/target width.
- MODE, 2, 0 = static not-taken, 1 = bimodal, 2 = gshare.
- PHT_IDX_W, 8, log2 of pattern history table entries (256).
- GHR_W, 8, global history length in bits (1..PHT_IDX_W).
- BTB_IDX_W, 6, log2 of BTB entries (64).
- TAG_W, 16, BTB tag width, taken from pc[BTB_IDX_W+2 +: TAG_W].
- CNT_W, 32, mispredict counter width.

Ports:
- in_Clk, input, 1, clock, rising edge.
- Rst, input, 1, asynchronous active-high reset.
- in_fetch_valid, input, 1, fetch PC valid this cycle.
- in_fetch_pc, input, XLEN, PC being fetched.
- out_prediction, output, 1, predict taken.
- out_pred_target, output, XLEN, predicted target (valid when out_prediction=1).
- out_pred_idx, output, PHT_IDX_W, PHT index used; carried down the pipe.
- out_ghr_snap, output, GHR_W, GHR value before this prediction; carried down the pipe.
- in_upd_valid, input, 1, resolved conditional branch this cycle.
- in_upd_pc, input, XLEN, PC of resolved branch.
- in_upd_idx, input, PHT_IDX_W, PHT index carried from fetch.
- in_upd_ghr, input, GHR_W, GHR snapshot carried from fetch.
- in_upd_taken, input, 1, actual outcome.
- in_upd_target, input, XLEN, actual target.
- in_upd_mispredict, input, 1, outcome or target differed from prediction.
- out_mispredict_cnt, output, CNT_W, saturating mispredict count.

Behaviour:
- Reset (async, any time including mid-update):
  - all PHT counters = 2'b01 (weakly not-taken);
  - all BTB valid bits = 0; GHR = 0; out_mispredict_cnt = 0.
  - Combinational outputs therefore read out_prediction = 0, out_pred_target = 0, out_pred_idx = index of the current PC, out_ghr_snap = 0.
- Lookup is combinational, zero latency, no bypass of same-cycle writes.
- Index:
  - MODE 1: idx = pc[PHT_IDX_W+1:2].
  - MODE 2: idx = pc[PHT_IDX_W+1:2] XOR zero-extended GHR.
  - MODE 0: idx = pc[PHT_IDX_W+1:2], unused.
- BTB hit: entry[pc[BTB_IDX_W+1:2]] valid and tag equal.
- out_prediction = (MODE != 0) & in_fetch_valid & counter[idx][1] & btb_hit. When out_prediction=0, out_pred_target = 0.
- GHR, evaluated on each in_Clk edge, priority order:
  1. in_upd_valid & in_upd_mispredict: GHR <= {in_upd_ghr[GHR_W-2:0], in_upd_taken}. Repair wins over a same-cycle fetch shift.
  2. else in_fetch_valid & MODE==2: GHR <= {GHR[GHR_W-2:0], out_prediction}.
  3. else hold.
  - GHR_W=1 case: the shift degenerates to the new bit alone.
- PHT update when in_upd_valid & MODE!=0 at in_upd_idx, saturating 2-bit counter:
  - taken: 11 stays 11, else +1;
  - not-taken: 00 stays 00, else -1.
- BTB update when in_upd_valid & in_upd_taken: write valid = 1, tag, target at the in_upd_pc index (overwrite, direct-mapped). A not-taken resolution leaves the BTB unchanged.
- Mispredict counter: +1 on in_upd_valid & in_upd_mispredict; saturates at all-ones.
- Simultaneous fetch and update to the same entry: fetch sees the pre-update value; the update lands at the edge.
- in_upd_* ignored when in_upd_valid=0.

Decomposition:
- Package bpu_pkg:
  - MODE_STATIC/MODE_BIMODAL/MODE_GSHARE localparams;
  - 2-bit counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - a saturating counter next-state function.
- Sub-module bpu_pht:
  - 2^PHT_IDX_W x 2-bit flop array;
  - one combinational read port, one synchronous write port;
  - async reset to WNT.
- BTB, GHR and the mispredict counter stay in the top module.

Test Plan:
- Reset: assert Rst mid-cycle after several updates -> same cycle all outputs reset values, cnt=0; a following lookup of a previously trained PC gives prediction=0.
- Training, MODE=2: branch PC 0x1000, target 0x0F00, resolve taken twice with mispredict=1 -> BTB hit, counter 01→10→11, prediction=1, target=0x0F00, cnt=2.
- Saturation: ten more taken updates -> counter stays 11; four not-taken updates -> 11→10→01→00→00, prediction=0.
- GHR repair: two fetches shift GHR 0x00→0x01→0x03; then update with mispredict, in_upd_ghr=0x00, taken=0, plus a same-cycle fetch -> GHR=0x00 (repair wins).
- Aliasing/tag: train PC 0x1000, fetch PC 0x1000+(1<<(BTB_IDX_W+2)) with the same index and a different tag -> btb miss, prediction=0.
- MODE=0 build: any training sequence -> out_prediction always 0; counter increments on mispredicts and saturates at 2^CNT_W-1 (test with CNT_W=4: 20 mispredicts -> 15).
